mem_arb: RTL and testbench

Two-port memory arbiter between the CPU's instruction-fetch (im_*) and data (dm_*) request/response interfaces and a single shared memory bus (bus_*). It sits between `cpu` and the unified memory/cache port at the SoC top level. It keeps at most one bus transaction outstanding, holds a grant stable until the bus accepts it, and returns each response only to the port that issued the request.

---
 rtl/mem_arb_if.sv | 44 ++++
 rtl/mem_arb.sv | 97 +++++++++
 tb/tb_mem_arb.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - instruction/data request-response ports and shared bus of mem_arb
interface mem_arb_if;
    logic [63:0] im_req_addr;
    logic        im_req_valid;
    logic        im_req_ready;
    logic [63:0] im_resp_rdata;
    logic        im_resp_valid;

    logic [63:0] dm_req_addr;
    logic [63:0] dm_req_wdata;
    logic [7:0]  dm_req_wmask;
    logic        dm_req_wen;
    logic        dm_req_valid;
    logic        dm_req_ready;
    logic [63:0] dm_resp_rdata;
    logic        dm_resp_valid;

    logic [63:0] bus_req_addr;
    logic [63:0] bus_req_wdata;
    logic [7:0]  bus_req_wmask;
    logic        bus_req_wen;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [63:0] bus_resp_rdata;
    logic        bus_resp_valid;

    modport slave (
        input  im_req_addr, im_req_valid,
        output im_req_ready, im_resp_rdata, im_resp_valid,
        input  dm_req_addr, dm_req_wdata, dm_req_wmask, dm_req_wen, dm_req_valid,
        output dm_req_ready, dm_resp_rdata, dm_resp_valid,
        output bus_req_addr, bus_req_wdata, bus_req_wmask, bus_req_wen, bus_req_valid,
        input  bus_req_ready, bus_resp_rdata, bus_resp_valid
    );

    modport master (
        output im_req_addr, im_req_valid,
        input  im_req_ready, im_resp_rdata, im_resp_valid,
        output dm_req_addr, dm_req_wdata, dm_req_wmask, dm_req_wen, dm_req_valid,
        input  dm_req_ready, dm_resp_rdata, dm_resp_valid,
        input  bus_req_addr, bus_req_wdata, bus_req_wmask, bus_req_wen, bus_req_valid,
        output bus_req_ready, bus_resp_rdata, bus_resp_valid
    );
endinterface

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-port memory arbiter, one outstanding bus transaction
// MEM_ARB_RR_EN selects round-robin arbitration; fixed dm-over-im priority otherwise.
module mem_arb (
    input  logic      clk,
    input  logic      rst,
    mem_arb_if.slave  arb
);
    typedef enum logic [1:0] {IDLE, WAIT_IM, WAIT_DM} state_t;
    localparam logic SEL_IM = 1'b0;
    localparam logic SEL_DM = 1'b1;

    state_t state, state_next;
    logic   lock, lock_next;
    logic   lock_sel, lock_sel_next;
    logic   last_sel, last_sel_next;
    logic   grant, grant_valid, handshake;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lock     <= 1'b0;
            lock_sel <= SEL_IM;
            last_sel <= SEL_IM;
        end else begin
            state    <= state_next;
            lock     <= lock_next;
            lock_sel <= lock_sel_next;
            last_sel <= last_sel_next;
        end
    end

    always_comb begin
        state_next    = state;
        lock_next     = lock;
        lock_sel_next = lock_sel;
        last_sel_next = last_sel;

        // A stalled request keeps its grant even if the other port becomes valid.
        grant = SEL_IM;
        if (lock) begin
            grant = lock_sel;
        end else begin
`ifdef MEM_ARB_RR_EN
            if (arb.im_req_valid && arb.dm_req_valid)
                grant = ~last_sel;
            else
                grant = arb.dm_req_valid ? SEL_DM : SEL_IM;
`else
            grant = arb.dm_req_valid ? SEL_DM : SEL_IM;
`endif
        end

        grant_valid       = (grant == SEL_DM) ? arb.dm_req_valid : arb.im_req_valid;
        arb.bus_req_valid = (state == IDLE) && grant_valid;
        handshake         = arb.bus_req_valid && arb.bus_req_ready;
        arb.im_req_ready  = handshake && (grant == SEL_IM);
        arb.dm_req_ready  = handshake && (grant == SEL_DM);

        arb.bus_req_addr  = 64'd0;
        arb.bus_req_wdata = 64'd0;
        arb.bus_req_wmask = 8'd0;
        arb.bus_req_wen   = 1'b0;
        if (arb.bus_req_valid) begin
            if (grant == SEL_DM) begin
                arb.bus_req_addr  = arb.dm_req_addr;
                arb.bus_req_wdata = arb.dm_req_wdata;
                arb.bus_req_wmask = arb.dm_req_wmask;
                arb.bus_req_wen   = arb.dm_req_wen;
            end else begin
                arb.bus_req_addr  = arb.im_req_addr;
            end
        end

        arb.im_resp_rdata = arb.bus_resp_rdata;
        arb.dm_resp_rdata = arb.bus_resp_rdata;
        arb.im_resp_valid = (state == WAIT_IM) && arb.bus_resp_valid;
        arb.dm_resp_valid = (state == WAIT_DM) && arb.bus_resp_valid;

        case (state)
            IDLE: begin
                if (handshake) begin
                    state_next    = (grant == SEL_DM) ? WAIT_DM : WAIT_IM;
                    last_sel_next = grant;
                    lock_next     = 1'b0;
                end else if (arb.bus_req_valid) begin
                    lock_next     = 1'b1;
                    lock_sel_next = grant;
                end
            end
            WAIT_IM, WAIT_DM: begin
                if (arb.bus_resp_valid)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - scoreboard bench for mem_arb with a latency-programmable bus responder
module tb_mem_arb;
    localparam logic SEL_IM = 1'b0;
    localparam logic SEL_DM = 1'b1;

    typedef struct {
        logic        port;
        logic        wr;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arb_if arb_if ();
    mem_arb dut (.clk(clk), .rst(rst), .arb(arb_if));

    exp_t sb[$];
    logic acc_order[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_im_resp = 0;
    int   n_dm_resp = 0;
    int   lat = 1;
    int   inject_id = 0;
    bit   im_oneshot = 1'b1;
    bit   dm_oneshot = 1'b1;
    bit   acc_im, acc_dm;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rd_data(input logic [63:0] a);
        return (a == 64'h8000_0000) ? 64'hDEAD_BEEF : (a ^ 64'h0123_4567_89AB_CDEF);
    endfunction

    // Bus model: one response per handshake, lat cycles later; dropped on reset.
    initial begin : responder
        logic        hs, hrst, pend;
        logic [63:0] hdata, pdata;
        int          cnt, seen_inject, hinj;
        pend = 1'b0;
        cnt = 0;
        pdata = 64'd0;
        seen_inject = 0;
        arb_if.bus_resp_valid = 1'b0;
        arb_if.bus_resp_rdata = 64'd0;
        forever begin
            @(negedge clk);
            hs    = arb_if.bus_req_valid && arb_if.bus_req_ready;
            hdata = arb_if.bus_req_wen ? 64'h0BAD : rd_data(arb_if.bus_req_addr);
            hrst  = rst;
            hinj  = inject_id;
            @(posedge clk);
            #1;
            arb_if.bus_resp_valid = 1'b0;
            if (hrst) begin
                pend = 1'b0;
            end else if (hinj != seen_inject) begin
                seen_inject = hinj;
                arb_if.bus_resp_valid = 1'b1;
                arb_if.bus_resp_rdata = 64'hFEED_F00D;
            end else if (hs) begin
                if (lat <= 1) begin
                    arb_if.bus_resp_valid = 1'b1;
                    arb_if.bus_resp_rdata = hdata;
                end else begin
                    pend = 1'b1;
                    cnt = lat - 1;
                    pdata = hdata;
                end
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    arb_if.bus_resp_valid = 1'b1;
                    arb_if.bus_resp_rdata = pdata;
                    pend = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (arb_if.im_resp_valid || arb_if.dm_resp_valid) begin
            if (arb_if.im_resp_valid) n_im_resp++;
            if (arb_if.dm_resp_valid) n_dm_resp++;
            check("resp_both_valid", {63'd0, arb_if.im_resp_valid && arb_if.dm_resp_valid}, 64'd0);
            if (sb.size() == 0) begin
                check("resp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("resp_port", {63'd0, arb_if.dm_resp_valid}, {63'd0, e.port});
                if (!e.wr)
                    check("resp_rdata", e.port ? arb_if.dm_resp_rdata : arb_if.im_resp_rdata, e.data);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        acc_im = arb_if.im_req_ready;
        acc_dm = arb_if.dm_req_ready;
        if (acc_im) begin
            sb.push_back('{port: SEL_IM, wr: 1'b0, data: rd_data(arb_if.im_req_addr)});
            acc_order.push_back(SEL_IM);
        end
        if (acc_dm) begin
            sb.push_back('{port: SEL_DM, wr: arb_if.dm_req_wen,
                           data: arb_if.dm_req_wen ? 64'd0 : rd_data(arb_if.dm_req_addr)});
            acc_order.push_back(SEL_DM);
        end
        @(posedge clk);
        #1;
        if (acc_im && im_oneshot) arb_if.im_req_valid = 1'b0;
        if (acc_dm && dm_oneshot) arb_if.dm_req_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (i < 40 && (sb.size() != 0 || arb_if.im_req_valid || arb_if.dm_req_valid)) begin
            tick();
            i++;
        end
        check("drain_timeout", {63'd0, (sb.size() != 0 || arb_if.im_req_valid || arb_if.dm_req_valid)}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        arb_if.im_req_valid = 1'b0;
        arb_if.dm_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        acc_order.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_im_ready"}, {63'd0, arb_if.im_req_ready}, 64'd0);
        check({tag, "_dm_ready"}, {63'd0, arb_if.dm_req_ready}, 64'd0);
        check({tag, "_im_resp_valid"}, {63'd0, arb_if.im_resp_valid}, 64'd0);
        check({tag, "_dm_resp_valid"}, {63'd0, arb_if.dm_resp_valid}, 64'd0);
        check({tag, "_bus_valid"}, {63'd0, arb_if.bus_req_valid}, 64'd0);
        check({tag, "_bus_addr"}, arb_if.bus_req_addr, 64'd0);
        check({tag, "_bus_wdata"}, arb_if.bus_req_wdata, 64'd0);
        check({tag, "_bus_wmask"}, {56'd0, arb_if.bus_req_wmask}, 64'd0);
        check({tag, "_bus_wen"}, {63'd0, arb_if.bus_req_wen}, 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int ticks, im_before, dm_before;
        logic exp_sel;
        rst = 1'b1;
        arb_if.im_req_addr = 64'd0;
        arb_if.im_req_valid = 1'b0;
        arb_if.dm_req_addr = 64'd0;
        arb_if.dm_req_wdata = 64'd0;
        arb_if.dm_req_wmask = 8'd0;
        arb_if.dm_req_wen = 1'b0;
        arb_if.dm_req_valid = 1'b0;
        arb_if.bus_req_ready = 1'b1;

        // Reset state
        do_reset();
        #1;
        check_idle_outputs("reset");

        // Single instruction read, 3-cycle bus latency
        lat = 3;
        arb_if.im_req_addr = 64'h8000_0000;
        arb_if.im_req_valid = 1'b1;
        #1;
        check("read_im_ready", {63'd0, arb_if.im_req_ready}, 64'd1);
        check("read_bus_valid", {63'd0, arb_if.bus_req_valid}, 64'd1);
        check("read_bus_addr", arb_if.bus_req_addr, 64'h8000_0000);
        check("read_bus_wen", {63'd0, arb_if.bus_req_wen}, 64'd0);
        drain();
        check("read_im_resp_count", n_im_resp, 1);
        check("read_dm_resp_count", n_dm_resp, 0);

        // Data store
        lat = 2;
        arb_if.dm_req_addr = 64'h1000;
        arb_if.dm_req_wdata = 64'h55;
        arb_if.dm_req_wmask = 8'h01;
        arb_if.dm_req_wen = 1'b1;
        arb_if.dm_req_valid = 1'b1;
        #1;
        check("store_dm_ready", {63'd0, arb_if.dm_req_ready}, 64'd1);
        check("store_bus_addr", arb_if.bus_req_addr, 64'h1000);
        check("store_bus_wdata", arb_if.bus_req_wdata, 64'h55);
        check("store_bus_wmask", {56'd0, arb_if.bus_req_wmask}, 64'h01);
        check("store_bus_wen", {63'd0, arb_if.bus_req_wen}, 64'd1);
        drain();
        check("store_im_resp_count", n_im_resp, 1);
        check("store_dm_resp_count", n_dm_resp, 1);

        // Contention: both valid, bus always ready, 1-cycle response
        do_reset();
        lat = 1;
        im_oneshot = 1'b0;
        dm_oneshot = 1'b0;
        arb_if.im_req_addr = 64'h2000;
        arb_if.dm_req_addr = 64'h3000;
        arb_if.dm_req_wen = 1'b0;
        arb_if.im_req_valid = 1'b1;
        arb_if.dm_req_valid = 1'b1;
        ticks = 0;
        while (acc_order.size() < 4 && ticks < 20) begin
            tick();
            ticks++;
        end
        arb_if.im_req_valid = 1'b0;
        arb_if.dm_req_valid = 1'b0;
        im_oneshot = 1'b1;
        dm_oneshot = 1'b1;
        check("contention_count", acc_order.size(), 4);
        check("contention_cycles", ticks, 7);
        for (int k = 0; k < 4 && k < acc_order.size(); k++) begin
`ifdef MEM_ARB_RR_EN
            exp_sel = (k % 2 == 0) ? SEL_DM : SEL_IM;
`else
            exp_sel = SEL_DM;
`endif
            check($sformatf("contention_grant_%0d", k), {63'd0, acc_order[k]}, {63'd0, exp_sel});
        end
        drain();

        // Grant hold under bus back-pressure
        acc_order.delete();
        lat = 2;
        arb_if.bus_req_ready = 1'b0;
        arb_if.im_req_addr = 64'h4000;
        arb_if.im_req_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                arb_if.dm_req_addr = 64'h5000;
                arb_if.dm_req_wdata = 64'h77;
                arb_if.dm_req_wmask = 8'hFF;
                arb_if.dm_req_wen = 1'b1;
                arb_if.dm_req_valid = 1'b1;
            end
            #1;
            check($sformatf("hold_addr_%0d", c), arb_if.bus_req_addr, 64'h4000);
            check($sformatf("hold_dm_ready_%0d", c), {63'd0, arb_if.dm_req_ready}, 64'd0);
            check($sformatf("hold_bus_valid_%0d", c), {63'd0, arb_if.bus_req_valid}, 64'd1);
            tick();
        end
        arb_if.bus_req_ready = 1'b1;
        #1;
        check("hold_im_ready", {63'd0, arb_if.im_req_ready}, 64'd1);
        check("hold_dm_ready_release", {63'd0, arb_if.dm_req_ready}, 64'd0);
        check("hold_addr_release", arb_if.bus_req_addr, 64'h4000);
        drain();
        check("hold_order_count", acc_order.size(), 2);
        if (acc_order.size() >= 2) begin
            check("hold_order_first", {63'd0, acc_order[0]}, {63'd0, SEL_IM});
            check("hold_order_second", {63'd0, acc_order[1]}, {63'd0, SEL_DM});
        end

        // Reset while a data read is in flight
        lat = 5;
        arb_if.dm_req_addr = 64'h6000;
        arb_if.dm_req_wen = 1'b0;
        arb_if.dm_req_valid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        im_before = n_im_resp;
        dm_before = n_dm_resp;
        inject_id++;
        @(negedge clk);
        @(posedge clk);
        #2;
        check_idle_outputs("midrst");
        check("midrst_dm_resp_count", n_dm_resp, dm_before);
        arb_if.im_req_addr = 64'h7000;
        arb_if.im_req_valid = 1'b1;
        #1;
        check("midrst_next_im_ready", {63'd0, arb_if.im_req_ready}, 64'd1);
        check("midrst_next_bus_addr", arb_if.bus_req_addr, 64'h7000);
        drain();
        check("midrst_im_resp_count", n_im_resp, im_before + 1);
        check("midrst_dm_resp_final", n_dm_resp, dm_before);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
